// File: rtl/tc_timer10_pkg.sv
// tc_timer10_pkg: shared terminal value and FSM state encoding for the 10-bit timer
package tc_timer10_pkg;
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] TERM = 10'h3FF;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/tc_timer10_and.sv
// tc_timer10_and: all-ones detector for the counter value
import tc_timer10_pkg::*;
module tc_timer10_and (
  input  logic [CNT_W-1:0] cnt_i,
  output logic             all_ones_o
);
  assign all_ones_o = &cnt_i;
endmodule

// File: rtl/tc_timer10.sv
// tc_timer10: 10-bit up-counting timer with period reload, one-shot/auto-reload modes and a tc pulse
import tc_timer10_pkg::*;
module tc_timer10 (
  input  logic             clk,
  input  logic             resetl,
  input  logic             per_ld,
  input  logic [CNT_W-1:0] per_d,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic             run,
  output logic             tc
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, cnt_q, cnt_d, eff_per;
  logic             tc_q, tc_d, term;
  tc_timer10_and u_and (
    .cnt_i      (cnt_q),
    .all_ones_o (term)
  );
  // a period loaded on the same edge as a (re)load takes effect immediately
  assign eff_per = per_ld ? per_d : per_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      cnt_d   = eff_per;
    end else if (state_q == RUN && tick) begin
      tc_d    = term;
      cnt_d   = !term ? cnt_q + 1'b1 : (mode ? cnt_q : eff_per);
      state_d = (term && mode) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      per_q   <= '0;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      if (per_ld) per_q <= per_d;
    end
  end
  assign cnt = cnt_q;
  assign run = (state_q == RUN);
  assign tc  = tc_q;
endmodule

// File: tb/tb_tc_timer10.sv
// tb_tc_timer10: directed self-checking bench for tc_timer10
module tb_tc_timer10;
  logic       clk, resetl, per_ld, start, stop, tick, mode;
  logic [9:0] per_d, cnt;
  logic       run, tc;
  int         checks = 0;
  int         errors = 0;
  tc_timer10 dut (
    .clk    (clk),
    .resetl (resetl),
    .per_ld (per_ld),
    .per_d  (per_d),
    .start  (start),
    .stop   (stop),
    .tick   (tick),
    .mode   (mode),
    .cnt    (cnt),
    .run    (run),
    .tc     (tc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input logic [9:0] ec, input logic er, input logic et);
    chk({tag, "_cnt"}, {6'd0, cnt}, {6'd0, ec});
    chk({tag, "_run"}, {15'd0, run}, {15'd0, er});
    chk({tag, "_tc"}, {15'd0, tc}, {15'd0, et});
  endtask
  logic [9:0] ar_cnt [9] = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h3FC, 10'h3FD};
  logic       ar_tc  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       g_tick [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [9:0] g_cnt  [4] = '{10'h3FE, 10'h3FE, 10'h3FE, 10'h3FF};
  initial begin
    resetl = 1'b0; per_ld = 0; per_d = '0; start = 0; stop = 0; tick = 0; mode = 0;
    #1;
    chk3("rst", 10'h000, 1'b0, 1'b0);
    @(negedge clk);
    resetl = 1'b1;
    step;
    chk3("idle0", 10'h000, 1'b0, 1'b0);
    per_d = 10'h3FC; per_ld = 1; start = 1; tick = 1; mode = 0;
    step;
    chk3("ar_start", 10'h3FC, 1'b1, 1'b0);
    per_ld = 0; start = 0;
    for (int i = 0; i < 9; i++) begin
      step;
      chk3($sformatf("ar%0d", i), ar_cnt[i], 1'b1, ar_tc[i]);
    end
    for (int i = 0; i < 4; i++) begin
      tick = g_tick[i];
      step;
      chk3($sformatf("gate%0d", i), g_cnt[i], 1'b1, 1'b0);
    end
    tick = 1; per_ld = 1; per_d = 10'h3FE;
    step;
    chk3("tc_bypass", 10'h3FE, 1'b1, 1'b1);
    per_ld = 0; start = 1; stop = 1;
    step;
    chk3("stop_prio", 10'h3FE, 1'b0, 1'b0);
    start = 0; stop = 0;
    step;
    chk3("idle_tick", 10'h3FE, 1'b0, 1'b0);
    per_d = 10'h3FF; per_ld = 1; start = 1; tick = 0; mode = 1;
    step;
    chk3("os_start", 10'h3FF, 1'b1, 1'b0);
    per_ld = 0; start = 0; tick = 1;
    step;
    chk3("os_tc", 10'h3FF, 1'b0, 1'b1);
    step;
    chk3("os_after", 10'h3FF, 1'b0, 1'b0);
    mode = 0; start = 1;
    step;
    chk3("p3ff_start", 10'h3FF, 1'b1, 1'b0);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk3($sformatf("p3ff%0d", i), 10'h3FF, 1'b1, 1'b1);
    end
    start = 1;
    step;
    chk3("restart", 10'h3FF, 1'b1, 1'b0);
    per_d = 10'h155; per_ld = 1; tick = 0;
    step;
    chk3("ld155", 10'h155, 1'b1, 1'b0);
    per_ld = 0; start = 0;
    #2;
    resetl = 1'b0;
    #1;
    chk3("rst_async", 10'h000, 1'b0, 1'b0);
    tick = 1;
    step;
    chk3("rst_hold", 10'h000, 1'b0, 1'b0);
    @(negedge clk);
    resetl = 1'b1;
    step;
    chk3("post_rst", 10'h000, 1'b0, 1'b0);
    start = 1; tick = 0;
    step;
    chk3("per_cleared", 10'h000, 1'b1, 1'b0);
    start = 0; tick = 1;
    step;
    chk3("inc_from0", 10'h001, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tc_timer10.md
TC_TIMER10 -- requirements
Module: tc_timer10

Interface
REQ-001 No parameters: counter width is fixed at 10 bits; terminal count is the all-ones value 0x3FF.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 resetl  input  1  asynchronous, active-low reset.
REQ-004 per_ld  input  1  load strobe for the period register.
REQ-005 per_d  input  10  period start value, sampled when per_ld=1.
REQ-006 start  input  1  start or restart the count.
REQ-007 stop  input  1  abort the count and return to idle.
REQ-008 tick  input  1  count-enable qualifier (prescaler strobe).
REQ-009 mode  input  1  0 = auto-reload, 1 = one-shot.
REQ-010 cnt  output  10  current counter value, registered.
REQ-011 run  output  1  high while in state RUN, registered.
REQ-012 tc  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-013 Period register per_reg SHALL load per_d on any edge with per_ld=1, in any state.
REQ-014 The FSM SHALL have two states, IDLE and RUN; run=1 exactly when the state is RUN.
REQ-015 In IDLE, start=1 and stop=0 SHALL load cnt with the effective period and enter RUN.
REQ-016 In RUN, start=1 and stop=0 SHALL reload cnt with the effective period (restart), stay in RUN and produce no tc.
REQ-017 The effective period SHALL be per_d when per_ld=1 on the same edge, otherwise per_reg (load bypass).
REQ-018 stop=1 SHALL force IDLE on the next edge with priority over start, tick and terminal count; cnt holds its value and tc=0.
REQ-019 In RUN with tick=1 and cnt!=0x3FF, cnt SHALL increment by 1; with tick=0, cnt SHALL hold.
REQ-020 In RUN with tick=1 and cnt=0x3FF (the AND of all 10 bits), the edge SHALL set tc=1 for exactly one cycle.
REQ-021 On that terminal-count edge with mode=0, cnt SHALL load the effective period and the FSM SHALL stay in RUN.
REQ-022 On that terminal-count edge with mode=1, cnt SHALL hold 0x3FF and the FSM SHALL enter IDLE.
REQ-023 The interval SHALL be 0x400 minus the period, in ticks; a period of 0x3FF gives tc on every tick.
REQ-024 tc SHALL be 0 on every edge that is not a terminal-count edge, including all edges in IDLE.
REQ-025 cnt SHALL never wrap to 0x000 by incrementing; reaching the terminal count always reloads or holds.
REQ-026 mode SHALL be sampled only on the terminal-count edge; changing it mid-count has no other effect.

Reset
REQ-027 resetl=0 SHALL immediately, without a clock, force state=IDLE, per_reg=0x000, cnt=0x000, run=0 and tc=0.
REQ-028 Reset asserted mid-count SHALL abandon the count; no tc is produced during or after reset.
REQ-029 After resetl deasserts, the first active edge SHALL behave as a normal IDLE edge.

Structure
REQ-030 The terminal value 0x3FF and the IDLE/RUN state encoding SHALL live in the shared timing package; no other typedefs are needed.
REQ-031 Terminal-count detection SHALL be one 10-input all-ones AND-reduction sub-block instantiated once, feeding the FSM; there are no other sub-modules.

Verification
REQ-032 Reset: assert resetl=0 mid-run with cnt=0x155 -> cnt=0x000, run=0 and tc=0 at once, with no clock edge needed.
REQ-033 Auto-reload: per_d=0x3FC with per_ld, start, mode=0, tick=1 held -> cnt runs 3FC,3FD,3FE,3FF,3FC... and tc pulses once every 4 cycles.
REQ-034 One-shot: per=0x3FF, mode=1, start, then tick=1 -> a single tc pulse, run=0 on the same edge, cnt stays 0x3FF.
REQ-035 Gating: tick toggling 1,0,0,1 from cnt=0x3FD -> cnt goes 3FE,3FE,3FE,3FF and tc stays 0.
REQ-036 Priority: start=1 and stop=1 on the same edge in RUN -> IDLE, cnt held, tc=0; per_ld of 0x3FE on a terminal-count edge -> cnt reloads 0x3FE.
